// File: rtl/fwd_axis_out.sv
//------------------------------------------------------------------------------
// fwd_axis_out
//
// Forwarder front end placed after the forward arbiter. It accepts a packet
// from the selected packetfilter core and reads its words out of the core
// buffer. It re-emits the packet as an AXI4-Stream master with tlast/tkeep,
// then pulses done to release the core. Reads are credit-limited against a
// small output FIFO, so no returned word is ever dropped, whatever the read
// latency or downstream backpressure.
//
// Optional feature macro: FWD_AXIS_LEN_USER_EN
//   When defined, adds m_axis_tuser [PLEN_WIDTH-1:0]. It carries the packet
//   byte length on every beat.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rdy / ack           arbiter packet available / forwarder accepts
//   addr, rd_en         core buffer word address and read strobe
//   rd_data, rd_data_vld returned word (byte k at [W-1-8k -: 8]) and valid
//   byte_len            packet length in bytes (sampled after settling)
//   done                one-cycle pulse releasing the core
//   m_axis_*            AXI4-Stream master (tdata, tkeep, tlast, tvalid,
//                       tready, optional tuser)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module fwd_axis_out #(
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int PLEN_WIDTH        = 32,
  parameter int SETTLE            = 2,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rdy,
  output logic                           ack,
  output logic [SN_FWD_ADDR_WIDTH-1:0]   addr,
  output logic                           rd_en,
  input  logic [SN_FWD_DATA_WIDTH-1:0]   rd_data,
  input  logic                           rd_data_vld,
  input  logic [PLEN_WIDTH-1:0]          byte_len,
  output logic                           done,
  output logic [SN_FWD_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [SN_FWD_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tvalid,
`ifdef FWD_AXIS_LEN_USER_EN
  output logic [PLEN_WIDTH-1:0]          m_axis_tuser,
`endif
  input  logic                           m_axis_tready
);

  localparam int BYTES     = SN_FWD_DATA_WIDTH / 8;
  localparam int NW_W      = SN_FWD_ADDR_WIDTH + 1;
  localparam int LEN_W1    = PLEN_WIDTH + 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W     = CNT_W + 1;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int ENT_W     = SN_FWD_DATA_WIDTH + 1 + BYTES;
  localparam int MAX_WORDS = 1 << SN_FWD_ADDR_WIDTH;
  localparam int SCNT_W    = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_READ   = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Keep mask for the final word: top rem bytes valid, rem==0 or a clamped
  // length means the word is full.
  function automatic logic [BYTES-1:0] last_keep(input logic [PLEN_WIDTH-1:0] rem,
                                                 input logic                  clamped);
    logic [BYTES-1:0] k;
    k = '1;
    if (!clamped && (rem != '0)) k = ~({BYTES{1'b1}} >> rem);
    return k;
  endfunction

  state_t                  state_q, state_d;
  logic                    ack_q;
  logic [SCNT_W-1:0]       settle_cnt_q;
  logic [NW_W-1:0]         nwords_q;
  logic [BYTES-1:0]        keep_last_q;
  logic [NW_W-1:0]         issued_q;
  logic [NW_W-1:0]         rcvd_q;
  logic [CNT_W-1:0]        inflight_q;

  logic [ENT_W-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        fifo_cnt_q;
  logic [ENT_W-1:0]        head;

  logic                    handshake, settle_last, credit_ok, push, pop;
  logic                    push_last;
  logic [BYTES-1:0]        push_keep;

  // Length decode, used only in the last settle cycle.
  logic [PLEN_WIDTH-1:0]   len_quot, len_rem;
  logic [LEN_W1-1:0]       words_raw;
  logic                    clamp;
  logic [NW_W-1:0]         nwords_d;

  assign len_quot  = byte_len / PLEN_WIDTH'(BYTES);
  assign len_rem   = byte_len % PLEN_WIDTH'(BYTES);
  assign words_raw = {1'b0, len_quot} + LEN_W1'(len_rem != '0);
  assign clamp     = words_raw > LEN_W1'(MAX_WORDS);
  assign nwords_d  = clamp ? NW_W'(MAX_WORDS) : words_raw[NW_W-1:0];

  assign handshake   = (state_q == S_IDLE) && rdy && ack_q;
  assign settle_last = (settle_cnt_q == SCNT_W'(SETTLE - 1));
  // Reserve FIFO space for every outstanding read before issuing another.
  assign credit_ok   = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < SUM_W'(FIFO_DEPTH);
  // Stray read returns outside an active packet are dropped.
  assign push        = rd_data_vld && ((state_q == S_READ) || (state_q == S_DRAIN));
  assign pop         = m_axis_tvalid && m_axis_tready;
  assign push_last   = (rcvd_q == (nwords_q - NW_W'(1)));
  assign push_keep   = push_last ? keep_last_q : '1;

  assign ack  = ack_q;
  assign addr = issued_q[SN_FWD_ADDR_WIDTH-1:0];
  assign done = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE:   if (handshake) state_d = S_SETTLE;
      S_SETTLE: if (settle_last) state_d = (nwords_d == '0) ? S_DONE : S_READ;
      S_READ: begin
        rd_en = credit_ok && (issued_q < nwords_q);
        if (issued_q == nwords_q) state_d = S_DRAIN;
      end
      // Leave DRAIN as the last beat pops so done lands one cycle later.
      S_DRAIN:  if ((inflight_q == '0) &&
                    ((fifo_cnt_q == '0) || ((fifo_cnt_q == CNT_W'(1)) && pop)))
                  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control stage: FSM, counters and read accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ack_q        <= 1'b0;
      settle_cnt_q <= '0;
      nwords_q     <= '0;
      keep_last_q  <= '0;
      issued_q     <= '0;
      rcvd_q       <= '0;
      inflight_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == S_IDLE);
      if (handshake) begin
        settle_cnt_q <= '0;
        issued_q     <= '0;
        rcvd_q       <= '0;
      end else begin
        if (state_q == S_SETTLE) settle_cnt_q <= settle_cnt_q + SCNT_W'(1);
        if (rd_en)               issued_q     <= issued_q + NW_W'(1);
        if (push)                rcvd_q       <= rcvd_q + NW_W'(1);
      end
      if ((state_q == S_SETTLE) && settle_last) begin
        nwords_q    <= nwords_d;
        keep_last_q <= last_keep(len_rem, clamp);
      end
      case ({rd_en, push})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

`ifdef FWD_AXIS_LEN_USER_EN
  logic [PLEN_WIDTH-1:0] len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
    end else if ((state_q == S_SETTLE) && settle_last) begin
      len_q <= byte_len;
    end
  end

  assign m_axis_tuser = len_q;
`endif

  // FIFO stage: storage {data, last, keep}, no reset on the data array.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {rd_data, push_last, push_keep};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Output stage: FIFO head, forced to zero while empty.
  assign head          = fifo_mem[rd_ptr_q];
  assign m_axis_tvalid = (fifo_cnt_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[ENT_W-1 -: SN_FWD_DATA_WIDTH] : '0;
  assign m_axis_tlast  = m_axis_tvalid & head[BYTES];
  assign m_axis_tkeep  = m_axis_tvalid ? head[BYTES-1:0] : '0;

endmodule

// File: tb/tb_fwd_axis_out.sv
`timescale 1ns/1ps
module tb_fwd_axis_out;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int PW = 32;
  localparam int ST = 2;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rdy = 1'b0;
  logic          ack;
  logic [AW-1:0] addr;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_data_vld;
  logic [PW-1:0] byte_len = '0;
  logic          done;
  logic [DW-1:0] tdata;
  logic [7:0]    tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready = 1'b1;
`ifdef FWD_AXIS_LEN_USER_EN
  logic [PW-1:0] tuser;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [15:0] cur_tag = 16'h0;

  fwd_axis_out #(
    .SN_FWD_ADDR_WIDTH(AW), .SN_FWD_DATA_WIDTH(DW), .PLEN_WIDTH(PW),
    .SETTLE(ST), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .ack(ack), .addr(addr), .rd_en(rd_en),
    .rd_data(rd_data), .rd_data_vld(rd_data_vld), .byte_len(byte_len), .done(done),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid),
`ifdef FWD_AXIS_LEN_USER_EN
    .m_axis_tuser(tuser),
`endif
    .m_axis_tready(tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] word_of(input logic [15:0] tag, input logic [AW-1:0] a);
    return {tag, 40'h0, a};
  endfunction

  // Core buffer model: read latency of two cycles.
  logic          lat_vld;
  logic [AW-1:0] lat_addr;
  always @(posedge clk) begin
    if (!rst_n) begin
      lat_vld     <= 1'b0;
      rd_data_vld <= 1'b0;
    end else begin
      lat_vld     <= rd_en;
      lat_addr    <= addr;
      rd_data_vld <= lat_vld;
      rd_data     <= word_of(cur_tag, lat_addr);
    end
  end

  // Monitor on the falling edge.
  logic [DW+8:0] beats[$];
  int            beat_cyc[$];
  logic [PW-1:0] beat_user[$];
  logic [AW-1:0] rd_addr[$];
  int            rd_cyc[$];
  int            done_cyc[$];
  int            outstanding = 0;
  int            credit_viol = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding <= 0;
    end else begin
      if (rd_en) begin
        if (outstanding >= FD) credit_viol <= credit_viol + 1;
        rd_addr.push_back(addr);
        rd_cyc.push_back(cyc);
      end
      if (tvalid && tready) begin
        beats.push_back({tdata, tkeep, tlast});
        beat_cyc.push_back(cyc);
`ifdef FWD_AXIS_LEN_USER_EN
        beat_user.push_back(tuser);
`else
        beat_user.push_back('0);
`endif
      end
      outstanding <= outstanding + (rd_en ? 1 : 0) - ((tvalid && tready) ? 1 : 0);
      if (done) done_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    beats.delete(); beat_cyc.delete(); beat_user.delete();
    rd_addr.delete(); rd_cyc.delete(); done_cyc.delete();
  endtask

  task automatic start_pkt(input logic [PW-1:0] len, output int h);
    byte_len = len;
    rdy = 1'b1;
    h = -1;
    for (int i = 0; i < 40; i++) begin
      if (ack) begin
        h = cyc;
        break;
      end
      tick();
    end
    n_checks++;
    if (h < 0) $display("FAIL handshake: ack=%0b, required 1", ack);
    else n_pass++;
    tick();
    rdy = 1'b0;
  endtask

  task automatic wait_done(input int n_before, input string name);
    int k;
    k = 0;
    while (done_cyc.size() <= n_before && k < 600) begin
      tick();
      k++;
    end
    n_checks++;
    if (done_cyc.size() <= n_before) $display("FAIL %s_done_timeout: done pulses=%0d, required %0d", name, done_cyc.size(), n_before + 1);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if ({ack, rd_en, done} !== 3'b000) $display("FAIL reset_ctrl: ack/rd_en/done=%b, required 000", {ack, rd_en, done});
    else n_pass++;
    n_checks++;
    if (addr !== '0) $display("FAIL reset_addr: addr=%h, required 00", addr);
    else n_pass++;
    n_checks++;
    if ({tvalid, tlast, tkeep} !== 10'h0) $display("FAIL reset_axis: tvalid/tlast/tkeep=%h, required 000", {tvalid, tlast, tkeep});
    else n_pass++;
    n_checks++;
    if (tdata !== '0) $display("FAIL reset_tdata: tdata=%h, required 0", tdata);
    else n_pass++;
`ifdef FWD_AXIS_LEN_USER_EN
    n_checks++;
    if (tuser !== '0) $display("FAIL reset_tuser: tuser=%0d, required 0", tuser);
    else n_pass++;
`endif
    rst_n = 1'b1;
    n_checks++;
    if (ack !== 1'b0) $display("FAIL ack_at_release: ack=%b, required 0", ack);
    else n_pass++;
    tick();
    n_checks++;
    if (ack !== 1'b1) $display("FAIL ack_after_release: ack=%b, required 1", ack);
    else n_pass++;
  endtask

  task automatic test_full_packet();
    int h;
    logic [DW+8:0] exp_b;
    cur_tag = 16'h1111;
    tready = 1'b1;
    clear_mon();
    start_pkt(64, h);
    wait_done(0, "full");
    n_checks++;
    if (ack !== 1'b1 || done !== 1'b0) $display("FAIL full_ack_after_done: ack/done=%b%b, required 10", ack, done);
    else n_pass++;
    n_checks++;
    if (beats.size() != 8) $display("FAIL full_beat_count: beats=%0d, required 8", beats.size());
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      exp_b = {word_of(16'h1111, AW'(i)), 8'hFF, (i == 7)};
      n_checks++;
      if (i >= beats.size()) $display("FAIL full_beat%0d: missing, required %h", i, exp_b);
      else if (beats[i] !== exp_b) $display("FAIL full_beat%0d: got %h, required %h", i, beats[i], exp_b);
      else n_pass++;
    end
    n_checks++;
    if (rd_cyc.size() == 0 || rd_cyc[0] != h + ST + 1) $display("FAIL full_first_rd: cycle=%0d, required %0d", (rd_cyc.size() > 0) ? rd_cyc[0] : -1, h + ST + 1);
    else n_pass++;
    n_checks++;
    if (done_cyc.size() != 1 || beat_cyc.size() != 8 || done_cyc[0] != beat_cyc[7] + 1)
      $display("FAIL full_done_timing: done=%0d pulses at %0d, required 1 at last pop+1 (%0d)", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, (beat_cyc.size() == 8) ? beat_cyc[7] + 1 : -1);
    else n_pass++;
  endtask

  task automatic test_short_13();
    int h;
    logic [DW+8:0] exp_b [2];
    cur_tag = 16'h2222;
    tready = 1'b1;
    clear_mon();
    start_pkt(13, h);
    wait_done(0, "short13");
    exp_b[0] = {word_of(16'h2222, 8'd0), 8'hFF, 1'b0};
    exp_b[1] = {word_of(16'h2222, 8'd1), 8'hF8, 1'b1};
    n_checks++;
    if (beats.size() != 2) $display("FAIL short13_beat_count: beats=%0d, required 2", beats.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (i >= beats.size()) $display("FAIL short13_beat%0d: missing, required %h", i, exp_b[i]);
      else if (beats[i] !== exp_b[i]) $display("FAIL short13_beat%0d: got %h, required %h", i, beats[i], exp_b[i]);
      else n_pass++;
`ifdef FWD_AXIS_LEN_USER_EN
      n_checks++;
      if (i >= beat_user.size() || beat_user[i] !== 32'd13) $display("FAIL short13_tuser%0d: got %0d, required 13", i, (i < beat_user.size()) ? beat_user[i] : 0);
      else n_pass++;
`endif
    end
    n_checks++;
    if (rd_addr.size() != 2 || rd_addr[0] !== 8'd0 || rd_addr[1] !== 8'd1) $display("FAIL short13_addrs: %0d reads, required 2 at 0,1", rd_addr.size());
    else n_pass++;
  endtask

  task automatic test_zero_len();
    int h;
    cur_tag = 16'h3333;
    tready = 1'b1;
    clear_mon();
    start_pkt(0, h);
    wait_done(0, "zero");
    n_checks++;
    if (rd_addr.size() != 0 || beats.size() != 0) $display("FAIL zero_no_traffic: reads=%0d beats=%0d, required 0 and 0", rd_addr.size(), beats.size());
    else n_pass++;
    n_checks++;
    if (done_cyc.size() == 0 || done_cyc[0] != h + ST + 1) $display("FAIL zero_done_cycle: got %0d, required %0d", (done_cyc.size() > 0) ? done_cyc[0] : -1, h + ST + 1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int h;
    int bad_addr;
    logic [DW+8:0] exp_b;
    cur_tag = 16'h4444;
    tready = 1'b0;
    clear_mon();
    start_pkt(200, h);
    for (int i = 0; i < 19; i++) tick();
    n_checks++;
    if (rd_addr.size() != FD) $display("FAIL bp_stall_reads: reads=%0d, required %0d", rd_addr.size(), FD);
    else n_pass++;
    n_checks++;
    if ({tvalid, tkeep, tdata} !== {1'b1, 8'hFF, word_of(16'h4444, 8'd0)}) $display("FAIL bp_head: got %h, required %h", {tvalid, tkeep, tdata}, {1'b1, 8'hFF, word_of(16'h4444, 8'd0)});
    else n_pass++;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if ({tvalid, tkeep, tdata} !== {1'b1, 8'hFF, word_of(16'h4444, 8'd0)}) $display("FAIL bp_head_stable: got %h, required %h", {tvalid, tkeep, tdata}, {1'b1, 8'hFF, word_of(16'h4444, 8'd0)});
    else n_pass++;
    tready = 1'b1;
    wait_done(0, "bp");
    n_checks++;
    if (beats.size() != 25) $display("FAIL bp_beat_count: beats=%0d, required 25", beats.size());
    else n_pass++;
    for (int i = 0; i < 25; i++) begin
      exp_b = {word_of(16'h4444, AW'(i)), 8'hFF, (i == 24)};
      n_checks++;
      if (i >= beats.size()) $display("FAIL bp_beat%0d: missing, required %h", i, exp_b);
      else if (beats[i] !== exp_b) $display("FAIL bp_beat%0d: got %h, required %h", i, beats[i], exp_b);
      else n_pass++;
    end
    bad_addr = 0;
    for (int i = 0; i < rd_addr.size(); i++) if (rd_addr[i] !== AW'(i)) bad_addr++;
    n_checks++;
    if (rd_addr.size() != 25 || bad_addr != 0) $display("FAIL bp_addrs: reads=%0d out_of_order=%0d, required 25 and 0", rd_addr.size(), bad_addr);
    else n_pass++;
    n_checks++;
    if (credit_viol != 0) $display("FAIL bp_credit: violations=%0d, required 0", credit_viol);
    else n_pass++;
    n_checks++;
    if (done_cyc.size() != 1) $display("FAIL bp_done_count: pulses=%0d, required 1", done_cyc.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int h;
    logic [DW+8:0] exp_b [2];
    cur_tag = 16'h5555;
    tready = 1'b1;
    clear_mon();
    start_pkt(64, h);
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (rd_en !== 1'b1) $display("FAIL rstmid_reading: rd_en=%b, required 1", rd_en);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ack, rd_en, done, addr} !== 11'h0) $display("FAIL rstmid_ctrl: ack/rd_en/done/addr=%h, required 000", {ack, rd_en, done, addr});
    else n_pass++;
    n_checks++;
    if ({tvalid, tlast, tkeep, tdata} !== 74'h0) $display("FAIL rstmid_axis: got %h, required 0", {tvalid, tlast, tkeep, tdata});
    else n_pass++;
    tick(); tick(); tick();
    n_checks++;
    if (done_cyc.size() != 0) $display("FAIL rstmid_no_done: pulses=%0d, required 0", done_cyc.size());
    else n_pass++;
    rst_n = 1'b1;
    clear_mon();
    tick();
    cur_tag = 16'h6666;
    start_pkt(13, h);
    wait_done(0, "rstmid_next");
    exp_b[0] = {word_of(16'h6666, 8'd0), 8'hFF, 1'b0};
    exp_b[1] = {word_of(16'h6666, 8'd1), 8'hF8, 1'b1};
    n_checks++;
    if (beats.size() != 2) $display("FAIL rstmid_next_count: beats=%0d, required 2", beats.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (i >= beats.size()) $display("FAIL rstmid_next_beat%0d: missing, required %h", i, exp_b[i]);
      else if (beats[i] !== exp_b[i]) $display("FAIL rstmid_next_beat%0d: got %h, required %h", i, beats[i], exp_b[i]);
      else n_pass++;
    end
    n_checks++;
    if (rd_addr.size() != 2 || rd_addr[0] !== 8'd0 || rd_addr[1] !== 8'd1) $display("FAIL rstmid_next_addrs: %0d reads, required 2 at 0,1", rd_addr.size());
    else n_pass++;
  endtask

  initial begin
    #2;
    test_reset();
    test_full_packet();
    tick(); tick();
    test_short_13();
    tick(); tick();
    test_zero_len();
    tick(); tick();
    test_backpressure();
    tick(); tick();
    test_reset_mid();
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
